// File: rtl/approx_cpa_pkg.sv
// Shared sizing helpers for the segmented carry-propagate adder that resolves
// CSA sum/carry pairs in the approximate multiplier datapath.
package approx_cpa_pkg;

    function automatic int unsigned NSEG(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

    function automatic int unsigned OUT_W(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/csa_resolve_adder_if.sv
// Valid/ready bundle between the CSA array, the resolving adder and its consumer.
interface csa_resolve_adder_if #(
    parameter int unsigned WIDTH = 24
) ();
    logic                                     IN_VALID;
    logic                                     IN_READY;
    logic [WIDTH-1:0]                         S;
    logic [WIDTH-1:0]                         C;
    logic                                     OUT_VALID;
    logic                                     OUT_READY;
    logic [approx_cpa_pkg::OUT_W(WIDTH)-1:0]  OUT_SUM;

    modport master (
        output IN_VALID, S, C, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_SUM
    );

    modport slave (
        input  IN_VALID, S, C, OUT_READY,
        output IN_READY, OUT_VALID, OUT_SUM
    );
endinterface

// File: rtl/cpa_seg_stage.sv
// One SEG-bit slice of the segmented carry-propagate adder: sum = a + b + cin.
module cpa_seg_stage #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
endmodule

// File: rtl/csa_resolve_adder.sv
// Pipelined resolver for a redundant CSA pair: OUT_SUM = S + 2*C, one SEG-bit
// segment per stage, full-throughput valid/ready with per-stage advance.
module csa_resolve_adder
    import approx_cpa_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SEG   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    csa_resolve_adder_if.slave bus
);
    localparam int unsigned NS = NSEG(WIDTH, SEG);

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("csa_resolve_adder: WIDTH must be a multiple of SEG");
    end

    // Operands shift right by SEG per stage so the next segment is always at
    // bit 0; resolved bits enter at the top of low and shift down likewise.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             c_top;
        logic [WIDTH-1:0] low;
        logic [WIDTH-1:0] s_rem;
        logic [WIDTH-1:0] c_rem;
    } stage_t;

    stage_t         q    [NS];
    stage_t         src  [NS];
    stage_t         nxt  [NS];
    logic [SEG-1:0] ssum [NS];
    logic           cout [NS];
    logic [NS-1:0]  v;
    logic [NS-1:0]  adv;

    function automatic stage_t advance(input stage_t s, input logic [SEG-1:0] sum, input logic co);
        stage_t r;
        r       = s;
        r.carry = co;
        r.low   = s.low >> SEG;
        r.low[WIDTH-1 -: SEG] = sum;
        r.s_rem = s.s_rem >> SEG;
        r.c_rem = s.c_rem >> SEG;
        return r;
    endfunction

    for (genvar k = 0; k < NS; k++) begin : g_stage
        if (k == 0) begin : g_head
            // C<<1 drops C[WIDTH-1] out of the segment window; it rides along as c_top.
            assign src[k] = '{valid: bus.IN_VALID, carry: 1'b0, c_top: bus.C[WIDTH-1],
                              low: '0, s_rem: bus.S, c_rem: {bus.C[WIDTH-2:0], 1'b0}};
        end else begin : g_body
            assign src[k] = q[k-1];
        end

        cpa_seg_stage #(.SEG(SEG)) u_seg (
            .a    (src[k].s_rem[SEG-1:0]),
            .b    (src[k].c_rem[SEG-1:0]),
            .cin  (src[k].carry),
            .sum  (ssum[k]),
            .cout (cout[k])
        );

        assign nxt[k] = advance(src[k], ssum[k], cout[k]);
    end

    always_comb begin
        v = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            v[k] = q[k].valid;
        end
    end

    // A stage may load when it or any stage downstream of it has a hole,
    // or when the consumer drains the last stage this cycle.
    always_comb begin
        logic full;
        adv  = '0;
        full = 1'b1;
        for (int unsigned i = 0; i < NS; i++) begin
            full            = full & v[NS-1-i];
            adv[NS-1-i]     = ~full | bus.OUT_READY;
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned k = 0; k < NS; k++) begin
            if (RST) begin
                q[k].valid <= 1'b0;
            end else if (adv[k]) begin
                q[k] <= nxt[k];
            end
        end
    end

    assign bus.IN_READY  = adv[0];
    assign bus.OUT_VALID = q[NS-1].valid;
    assign bus.OUT_SUM   = q[NS-1].valid
                         ? {{1'b0, q[NS-1].carry} + {1'b0, q[NS-1].c_top}, q[NS-1].low}
                         : '0;
endmodule

// File: tb/tb_csa_resolve_adder.sv
// Self-checking bench: directed 24/8 vectors and corner sequences, plus a
// randomized 16/4 instance, both checked through expected-result queues.
module tb_csa_resolve_adder;
    localparam int unsigned W  = 24;
    localparam int unsigned RW = 16;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst16 = 1'b1;
    always #5 clk = ~clk;

    csa_resolve_adder_if #(.WIDTH(W))  bus24 ();
    csa_resolve_adder_if #(.WIDTH(RW)) bus16 ();

    csa_resolve_adder #(.WIDTH(W), .SEG(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus24)
    );

    csa_resolve_adder #(.WIDTH(RW), .SEG(4)) dut16 (
        .CLK (clk),
        .RST (rst16),
        .bus (bus16)
    );

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W+1:0] exp;
    } vec_t;

    vec_t          vecs [11];
    int            total  = 0;
    int            bad    = 0;
    int            n_out24 = 0;
    logic [W+1:0]  q24 [$];
    logic [RW+1:0] q16 [$];
    logic          hold16 = 1'b0;
    logic [RW+1:0] held16 = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [W+1:0] model24(input logic [W-1:0] s, input logic [W-1:0] c);
        return {2'b00, s} + {1'b0, c, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus24.OUT_VALID && bus24.OUT_READY) begin
            n_out24++;
            if (q24.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out24_unexpected: got %0h want none", bus24.OUT_SUM);
            end else begin
                chk("out24", 64'(bus24.OUT_SUM), 64'(q24.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst16) begin
            hold16 = 1'b0;
        end else begin
            if (hold16) begin
                chk("stall16_valid", 64'(bus16.OUT_VALID), 64'(1));
                chk("stall16_sum", 64'(bus16.OUT_SUM), 64'(held16));
            end
            if (bus16.OUT_VALID && bus16.OUT_READY) begin
                if (q16.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out16_unexpected: got %0h want none", bus16.OUT_SUM);
                end else begin
                    chk("out16", 64'(bus16.OUT_SUM), 64'(q16.pop_front()));
                end
            end
            hold16 = bus16.OUT_VALID && !bus16.OUT_READY;
            held16 = bus16.OUT_SUM;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send24(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W+1:0] exp);
        int unsigned guard = 0;
        bus24.IN_VALID = 1'b1;
        bus24.S        = s;
        bus24.C        = c;
        @(negedge clk);
        while (!bus24.IN_READY && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!bus24.IN_READY) begin
            chk("accept24_timeout", 64'(bus24.IN_READY), 64'(1));
        end else begin
            q24.push_back(exp);
        end
        @(posedge clk);
        #1;
        bus24.IN_VALID = 1'b0;
    endtask

    task automatic drain24(input string name);
        int unsigned g = 0;
        while (q24.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk(name, 64'(q24.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]  bp_s [5];
        logic [W-1:0]  bp_c [5];
        logic [W+1:0]  bp_e [5];
        int            base;
        int unsigned   acc  = 0;
        int unsigned   cyc  = 0;
        logic          took = 1'b0;
        int unsigned   g    = 0;

        vecs[0]  = '{24'h00FFFF, 24'h000001, 26'h0010001};
        vecs[1]  = '{24'h000000, 24'h800000, 26'h1000000};
        vecs[2]  = '{24'h000000, 24'h000000, 26'h0000000};
        vecs[3]  = '{24'h123456, 24'h000000, 26'h0123456};
        vecs[4]  = '{24'h000000, 24'h7FFFFF, 26'h0FFFFFE};
        vecs[5]  = '{24'hFFFFFF, 24'h000001, 26'h1000001};
        vecs[6]  = '{24'h0000FF, 24'h000080, 26'h00001FF};
        vecs[7]  = '{24'h00FF00, 24'h008000, 26'h001FF00};
        vecs[8]  = '{24'hABCDEF, 24'h111111, 26'h0CDF011};
        vecs[9]  = '{24'h800000, 24'h800000, 26'h1800000};
        vecs[10] = '{24'hFFFFFF, 24'h800000, 26'h1FFFFFF};

        bus24.IN_VALID = 1'b0;
        bus24.S = '0;
        bus24.C = '0;
        bus24.OUT_READY = 1'b1;
        bus16.IN_VALID = 1'b0;
        bus16.S = '0;
        bus16.C = '0;
        bus16.OUT_READY = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus24.IN_READY), 64'(1));
        chk("rst_out_valid", 64'(bus24.OUT_VALID), 64'(0));
        chk("rst_out_sum", 64'(bus24.OUT_SUM), 64'(0));
        chk("rst16_in_ready", 64'(bus16.IN_READY), 64'(1));
        @(posedge clk);
        #1;

        // Saturation and exact 3-cycle latency
        bus24.IN_VALID = 1'b1;
        bus24.S = 24'hFFFFFF;
        bus24.C = 24'hFFFFFF;
        @(negedge clk);
        chk("sat_accept", 64'(bus24.IN_READY), 64'(1));
        q24.push_back(26'h2FFFFFD);
        @(posedge clk);
        #1;
        bus24.IN_VALID = 1'b0;
        @(negedge clk);
        chk("sat_lat1", 64'(bus24.OUT_VALID), 64'(0));
        @(negedge clk);
        chk("sat_lat2", 64'(bus24.OUT_VALID), 64'(0));
        @(negedge clk);
        chk("sat_lat3", 64'(bus24.OUT_VALID), 64'(1));
        chk("sat_sum", 64'(bus24.OUT_SUM), 64'(26'h2FFFFFD));
        @(posedge clk);
        #1;
        drain24("sat_drain");

        // Table vectors, streamed back to back
        for (int i = 0; i < 11; i++) begin
            send24(vecs[i].s, vecs[i].c, vecs[i].exp);
        end
        drain24("table_drain");

        // Backpressure: three fill the pipe, the rest wait for OUT_READY
        for (int i = 0; i < 5; i++) begin
            bp_s[i] = 24'($urandom);
            bp_c[i] = 24'($urandom);
            bp_e[i] = model24(bp_s[i], bp_c[i]);
        end
        base = n_out24;
        bus24.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send24(bp_s[i], bp_c[i], bp_e[i]);
        end
        bus24.IN_VALID = 1'b1;
        bus24.S = bp_s[3];
        bus24.C = bp_c[3];
        @(negedge clk);
        chk("bp_full_ready", 64'(bus24.IN_READY), 64'(0));
        chk("bp_hold_valid", 64'(bus24.OUT_VALID), 64'(1));
        chk("bp_hold_sum", 64'(bus24.OUT_SUM), 64'(bp_e[0]));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_full_ready2", 64'(bus24.IN_READY), 64'(0));
        chk("bp_hold_sum2", 64'(bus24.OUT_SUM), 64'(bp_e[0]));
        @(posedge clk);
        #1;
        bus24.OUT_READY = 1'b1;
        send24(bp_s[3], bp_c[3], bp_e[3]);
        send24(bp_s[4], bp_c[4], bp_e[4]);
        drain24("bp_drain");
        chk("bp_count", 64'(n_out24 - base), 64'(5));

        // Two-cycle reset with two pairs in flight
        send24(24'h111111, 24'h222222, model24(24'h111111, 24'h222222));
        send24(24'h333333, 24'h444444, model24(24'h333333, 24'h444444));
        rst = 1'b1;
        q24.delete();
        base = n_out24;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst2_out_valid", 64'(bus24.OUT_VALID), 64'(0));
        chk("rst2_out_sum", 64'(bus24.OUT_SUM), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_in_ready", 64'(bus24.IN_READY), 64'(1));
        chk("rst2_out_valid_after", 64'(bus24.OUT_VALID), 64'(0));
        repeat (5) @(negedge clk);
        chk("rst2_no_output", 64'(n_out24 - base), 64'(0));
        @(posedge clk);
        #1;

        // One-cycle reset with two pairs in flight, then a clean pair
        send24(24'h0F0F0F, 24'h0F0F0F, model24(24'h0F0F0F, 24'h0F0F0F));
        send24(24'hF0F0F0, 24'hF0F0F0, model24(24'hF0F0F0, 24'hF0F0F0));
        rst = 1'b1;
        q24.delete();
        base = n_out24;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst1_no_output", 64'(n_out24 - base), 64'(0));
        @(posedge clk);
        #1;
        send24(24'h7FFFFF, 24'h400001, 26'h0FFFFFF + 26'h0000002);
        drain24("rst1_drain");
        chk("rst1_count", 64'(n_out24 - base), 64'(1));

        // Random traffic on the 16/4 instance
        while (acc < 10000 && cyc < 40000) begin
            @(posedge clk);
            #1;
            cyc++;
            bus16.OUT_READY = ($urandom_range(0, 9) < 7);
            if (!bus16.IN_VALID || took) begin
                bus16.IN_VALID = ($urandom_range(0, 3) != 0);
                bus16.S = 16'($urandom);
                bus16.C = 16'($urandom);
            end
            @(negedge clk);
            took = bus16.IN_VALID && bus16.IN_READY;
            if (took) begin
                acc++;
                q16.push_back({2'b00, bus16.S} + {1'b0, bus16.C, 1'b0});
            end
        end
        @(posedge clk);
        #1;
        bus16.IN_VALID = 1'b0;
        bus16.OUT_READY = 1'b1;
        chk("rand_accepts", 64'(acc), 64'(10000));
        while (q16.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("rand_drain", 64'(q16.size()), 64'(0));
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
